// File: rtl/latch_map_gen_if.sv
// CPU/PPU bus bundle between the cartridge slot and the latch_map_gen mapper core.
// Widths track the mapper's inner/outer bank parameters.
interface latch_map_gen_if #(
  parameter int PRG_BW   = 2,
  parameter int CHR_BW   = 3,
  parameter int OUTER_BW = 2
);
  logic [15:0]                    cpu_addr;
  logic [7:0]                     cpu_dat;
  logic                           cpu_rw;
  logic                           cpu_ce;
  logic [7:0]                     prg_dout;
  logic [13:0]                    ppu_addr;
  logic                           cfg_mir_v;
  logic                           ss_act;
  logic                           ss_we;
  logic [7:0]                     ss_addr;
  logic [15+PRG_BW+OUTER_BW-1:0]  prg_addr;
  logic [13+CHR_BW+OUTER_BW-1:0]  chr_addr;
  logic                           ciram_a10;
  logic [7:0]                     ss_rdat;
  logic                           locked;

  modport master (
    output cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dout, ppu_addr, cfg_mir_v,
           ss_act, ss_we, ss_addr,
    input  prg_addr, chr_addr, ciram_a10, ss_rdat, locked
  );

  modport slave (
    input  cpu_addr, cpu_dat, cpu_rw, cpu_ce, prg_dout, ppu_addr, cfg_mir_v,
           ss_act, ss_we, ss_addr,
    output prg_addr, chr_addr, ciram_a10, ss_rdat, locked
  );
endinterface

// File: rtl/latch_map_gen.sv
// Parametrised discrete-latch NES mapper: inner PRG/CHR/mirroring latch, lockable outer bank,
// save-state port. Optional bus-conflict emulation enabled by LATCH_MAP_BUS_CONFLICT_EN.
//
// state  | meaning
// OPEN   | outer bank register accepts $5000-$5FFF writes
// LOCKED | outer bank frozen until reset or save-state restore
module latch_map_gen #(
  parameter int       PRG_BW   = 2,
  parameter int       CHR_BW   = 3,
  parameter int       SRC      = 0,
  parameter int       PRG_WIN  = 32,
  parameter int       MIR_CTL  = 1,
  parameter int       OUTER_BW = 2,
  parameter bit [7:0] MAP_IDX  = 8'd216
) (
  input logic          m2,
  input logic          map_rst_n,
  latch_map_gen_if.slave bus
);
  localparam int LW  = PRG_BW + CHR_BW + 1;
  localparam int OW  = (OUTER_BW > 0) ? OUTER_BW : 1;
  localparam int PAW = 15 + PRG_BW + OUTER_BW;
  localparam int CAW = 13 + CHR_BW + OUTER_BW;

  if (PRG_BW < 1 || PRG_BW > 6) begin : g_bad_prg
    $error("latch_map_gen: PRG_BW out of range 1..6");
  end
  if (CHR_BW < 1 || CHR_BW > 6) begin : g_bad_chr
    $error("latch_map_gen: CHR_BW out of range 1..6");
  end
  if (OUTER_BW < 0 || OUTER_BW > 4) begin : g_bad_outer
    $error("latch_map_gen: OUTER_BW out of range 0..4");
  end
  if ((SRC == 1 && LW > 8) || (SRC == 0 && LW > 15)) begin : g_bad_lw
    $error("latch_map_gen: latch word too wide for the selected source");
  end
  if (PRG_WIN != 16 && PRG_WIN != 32) begin : g_bad_win
    $error("latch_map_gen: PRG_WIN must be 16 or 32");
  end

  typedef enum logic {OPEN = 1'b0, LOCKED = 1'b1} lock_t;

  lock_t             state, state_nxt;
  logic [LW-1:0]     lat, lat_nxt;
  logic [OW-1:0]     outer, outer_nxt;
  logic [OW-1:0]     dat_outer;
  logic [7:0]        eff_dat;
  logic [14:0]       src_val;
  logic [14:0]       lx;
  logic [14:0]       lx_w;
  logic [PRG_BW-1:0] prg;
  logic [CHR_BW-1:0] chr;
  logic [PRG_BW-1:0] bank;

`ifdef LATCH_MAP_BUS_CONFLICT_EN
  // The ROM drives the bus during the write, so open-drain style AND with its output.
  assign eff_dat = (SRC == 1) ? (bus.cpu_dat & bus.prg_dout) : bus.cpu_dat;
`else
  assign eff_dat = bus.cpu_dat;
`endif

  assign src_val   = (SRC == 0) ? bus.cpu_addr[14:0] : {7'b0, eff_dat};
  assign dat_outer = (OUTER_BW > 0) ? bus.cpu_dat[OW-1:0] : '0;
  assign lx        = 15'(lat);
  assign prg       = lat[PRG_BW-1:0];
  assign chr       = lat[PRG_BW+CHR_BW-1:PRG_BW];

  always_ff @(negedge m2 or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state <= OPEN;
      lat   <= '0;
      outer <= '0;
    end else begin
      state <= state_nxt;
      lat   <= lat_nxt;
      outer <= outer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    outer_nxt = outer;
    lx_w      = lx;
    if (bus.ss_act) begin
      if (bus.ss_we) begin
        case (bus.ss_addr)
          8'd0: begin
            lx_w[7:0] = bus.cpu_dat;
            lat_nxt   = lx_w[LW-1:0];
          end
          8'd1: begin
            lx_w[14:8] = bus.cpu_dat[6:0];
            lat_nxt    = lx_w[LW-1:0];
          end
          8'd2: begin
            state_nxt = lock_t'(bus.cpu_dat[7]);
            outer_nxt = dat_outer;
          end
          default: ;
        endcase
      end
    end else if (!bus.cpu_rw) begin
      if (!bus.cpu_ce) begin
        lat_nxt = src_val[LW-1:0];
      end else if (bus.cpu_addr[15:12] == 4'h5 && state == OPEN) begin
        outer_nxt = dat_outer;
        if (bus.cpu_dat[7]) state_nxt = LOCKED;
      end
    end
  end

  always_comb begin
    bank = bus.cpu_addr[14] ? '1 : prg;
    if (PRG_WIN == 16) begin
      bus.prg_addr = (PAW'(outer) << (14 + PRG_BW)) | (PAW'(bank) << 14)
                   | PAW'(bus.cpu_addr[13:0]);
    end else begin
      bus.prg_addr = (PAW'(outer) << (15 + PRG_BW)) | (PAW'(prg) << 15)
                   | PAW'(bus.cpu_addr[14:0]);
    end
  end

  assign bus.chr_addr = (CAW'(outer) << (13 + CHR_BW)) | (CAW'(chr) << 13)
                      | CAW'(bus.ppu_addr[12:0]);

  assign bus.ciram_a10 = (MIR_CTL != 0)
                       ? (lat[LW-1] ? bus.ppu_addr[11] : bus.ppu_addr[10])
                       : (bus.cfg_mir_v ? bus.ppu_addr[10] : bus.ppu_addr[11]);

  assign bus.locked = (state == LOCKED);

  always_comb begin
    case (bus.ss_addr)
      8'd0:    bus.ss_rdat = lx[7:0];
      8'd1:    bus.ss_rdat = {1'b0, lx[14:8]};
      8'd2:    bus.ss_rdat = {(state == LOCKED), 3'b0, 4'(outer)};
      8'd127:  bus.ss_rdat = MAP_IDX;
      default: bus.ss_rdat = 8'hFF;
    endcase
  end

  // Inputs only consumed in some parameter/macro combinations.
  logic unused;
  assign unused = ^{bus.prg_dout, bus.cfg_mir_v, bus.ppu_addr[13], src_val, lx_w};
endmodule
